// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Holds the FSM state enum, nibble width and nibble-count helper.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_nibbles(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result bundle for the nibble-serial adder.
// Optional sub signal exists only when SUBTRACT_EN is defined.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
`ifdef SUBTRACT_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             zero;

  modport master (
`ifdef SUBTRACT_EN
    output sub,
`endif
    output start, op_a, op_b, cin,
    input  busy, done, sum, cout, zero
  );

  modport slave (
`ifdef SUBTRACT_EN
    input  sub,
`endif
    input  start, op_a, op_b, cin,
    output busy, done, sum, cout, zero
  );

endinterface

// File: rtl/nibble_serial_adder_cla4.sv
// Combinational 4-bit carry-lookahead slice.
// Provides sum, carry-out and group propagate/generate.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       c4,
  output logic       pg,
  output logic       gg
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  assign w_c[0] = c0;
  assign w_c[1] = w_g[0]
                | (w_p[0] & c0);
  assign w_c[2] = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & c0);
  assign w_c[3] = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & c0);

  assign pg = &w_p;
  assign gg = w_g[3]
            | (w_p[3] & w_g[2])
            | (w_p[3] & w_p[2] & w_g[1])
            | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

  assign c4 = gg | (pg & c0);
  assign s  = w_p ^ w_c;

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit CLA slice, one nibble per RUN cycle.
// Define SUBTRACT_EN to add the sub input (op_a + ~op_b + 1).
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst,
  nibble_serial_adder_if.slave bus
);

  localparam int NQ    = num_nibbles(WIDTH);
  localparam int IDX_W = $clog2(NQ);

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
      $error("WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_cout;
  logic               r_zero;

  logic               w_accept;
  logic               w_last;
  logic [IDX_W+1:0]   w_bit;
  logic [3:0]         w_a_nib;
  logic [3:0]         w_b_nib;
  logic [3:0]         w_s_nib;
  logic               w_c4;
  logic               w_unused_pg;
  logic               w_unused_gg;
  logic [WIDTH-1:0]   w_sum_upd;
  logic [WIDTH-1:0]   w_b_in;
  logic               w_c_in;

`ifdef SUBTRACT_EN
  assign w_b_in = bus.sub ? ~bus.op_b : bus.op_b;
  assign w_c_in = bus.sub ? 1'b1 : bus.cin;
`else
  assign w_b_in = bus.op_b;
  assign w_c_in = bus.cin;
`endif

  assign w_bit   = {r_idx, 2'b00};
  assign w_a_nib = r_a[w_bit +: NIBBLE_W];
  assign w_b_nib = r_b[w_bit +: NIBBLE_W];

  cla4 u_cla4 (
    .a  (w_a_nib),
    .b  (w_b_nib),
    .c0 (r_carry),
    .s  (w_s_nib),
    .c4 (w_c4),
    .pg (w_unused_pg),
    .gg (w_unused_gg)
  );

  // Merge the current slice result into the running sum
  always_comb begin
    w_sum_upd = r_sum;
    w_sum_upd[w_bit +: NIBBLE_W] = w_s_nib;
  end

  // Next-state and control decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_idx == IDX_W'(NQ - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operand capture, per-nibble accumulation and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_zero  <= 1'b1;
    end else if (w_accept) begin
      r_idx   <= '0;
      r_a     <= bus.op_a;
      r_b     <= w_b_in;
      r_sum   <= '0;
      r_carry <= w_c_in;
      r_cout  <= 1'b0;
      r_zero  <= 1'b1;
    end else if (r_state == RUN) begin
      r_sum   <= w_sum_upd;
      r_carry <= w_c4;
      r_idx   <= r_idx + IDX_W'(1);
      if (w_last) begin
        r_cout <= w_c4;
        r_zero <= (w_sum_upd == '0);
      end
    end
  end

  assign bus.busy = (r_state != IDLE);
  assign bus.done = (r_state == DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.zero = r_zero;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16).
// Cycle-level reference model plus directed literal checks.
module tb_nibble_serial_adder;
  import nibble_serial_adder_pkg::*;

  localparam int W  = 16;
  localparam int NQ = W / 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  nibble_serial_adder_if #(.WIDTH(W)) bus ();

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int e_cnt  = 0;
  int t0     = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [W:0] calc(input logic [W-1:0] a,
                                      input logic [W-1:0] b,
                                      input logic c,
                                      input logic s);
    if (s) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + (W+1)'(c);
  endfunction

  // Reference model: an op accepted at edge t finishes its RUN
  // after edge t+NQ, shows done in the following cycle, and
  // returns to idle at edge t+NQ+1.
  bit           m_init = 1'b0;
  bit           m_act  = 1'b0;
  int           m_t0   = 0;
  logic [W:0]   m_full;
  logic [W-1:0] m_sum;
  logic         m_cout;
  logic         m_zero;
  logic         m_sub_in;

  always @(posedge clk) begin
    e_cnt++;
`ifdef SUBTRACT_EN
    m_sub_in = bus.sub;
`else
    m_sub_in = 1'b0;
`endif
    if (rst) begin
      m_init = 1'b1;
      m_act  = 1'b0;
      m_sum  = '0;
      m_cout = 1'b0;
      m_zero = 1'b1;
    end else if (m_init) begin
      if (m_act) begin
        if (e_cnt - m_t0 == NQ) begin
          m_sum  = m_full[W-1:0];
          m_cout = m_full[W];
          m_zero = (m_full[W-1:0] == '0);
        end else if (e_cnt - m_t0 == NQ + 1) begin
          m_act = 1'b0;
        end
      end else if (bus.start) begin
        m_act  = 1'b1;
        m_t0   = e_cnt;
        m_full = calc(bus.op_a, bus.op_b, bus.cin, m_sub_in);
      end
    end
  end

  // Compare DUT against the model every cycle
  always @(negedge clk) begin
    if (m_init) begin
      logic m_done;
      m_done = m_act && (e_cnt - m_t0 == NQ);
      chk("busy", 32'(bus.busy), 32'(m_act));
      chk("done", 32'(bus.done), 32'(m_done));
      if (!m_act || m_done) begin
        chk("sum",  32'(bus.sum),  32'(m_sum));
        chk("cout", 32'(bus.cout), 32'(m_cout));
        chk("zero", 32'(bus.zero), 32'(m_zero));
      end
    end
  end

  task automatic set_sub(input logic s);
`ifdef SUBTRACT_EN
    bus.sub = s;
`else
    if (s) $display("note: sub ignored without SUBTRACT_EN");
`endif
  endtask

  task automatic start_op(input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic c,
                          input logic s);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = c;
    set_sub(s);
    bus.start = 1'b1;
    t0 = e_cnt + 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output bit ok, output int lat);
    ok  = 1'b0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        ok  = 1'b1;
        lat = e_cnt + 1 - t0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic expect_result(input string nm,
                               input logic [W-1:0] s,
                               input logic co,
                               input logic z);
    bit ok;
    int lat;
    wait_done(ok, lat);
    chk({nm, "_seen"}, 32'(ok), 32'd1);
    if (ok) begin
      chk({nm, "_lat"},  32'(lat),      32'd5);
      chk({nm, "_sum"},  32'(bus.sum),  32'(s));
      chk({nm, "_cout"}, 32'(bus.cout), 32'(co));
      chk({nm, "_zero"}, 32'(bus.zero), 32'(z));
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    int first_d;
    int last_d;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.cin   = 1'b0;
    set_sub(1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum",  32'(bus.sum),  32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd1);

    start_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    expect_result("v1", 16'h0100, 1'b0, 1'b0);

    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    expect_result("v2", 16'h0000, 1'b1, 1'b1);

    bus.op_a  = 16'h1234;
    bus.op_b  = 16'h4321;
    bus.cin   = 1'b1;
    bus.start = 1'b1;
    t0 = e_cnt + 1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = 16'hFFFF;
    bus.op_b  = 16'hFFFF;
    bus.cin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    expect_result("v3", 16'h5556, 1'b0, 1'b0);
    @(negedge clk);
    chk("v3_noqueue", 32'(bus.busy), 32'd0);

    start_op(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_sum",  32'(bus.sum),  32'd0);
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done) n_done++;
      @(negedge clk);
    end
    chk("abort_nodone", 32'(n_done), 32'd0);
    start_op(16'h0001, 16'h0001, 1'b0, 1'b0);
    expect_result("v4", 16'h0002, 1'b0, 1'b0);

    start_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    expect_result("v5", 16'hFFFF, 1'b1, 1'b0);

    start_op(16'h8000, 16'h8000, 1'b0, 1'b0);
    expect_result("v6", 16'h0000, 1'b1, 1'b1);

    rst       = 1'b1;
    bus.start = 1'b1;
    bus.op_a  = 16'h0003;
    @(negedge clk);
    chk("rst_prio", 32'(bus.busy), 32'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);

    n_done  = 0;
    first_d = 0;
    last_d  = 0;
    for (int i = 0; i < 20; i++) begin
      bus.op_a  = W'(i * 16'h0F0F + 1);
      bus.op_b  = W'(16'hFFFF - i * 3);
      bus.cin   = i[0];
      bus.start = 1'b1;
      @(negedge clk);
      if (bus.done) begin
        if (n_done == 0) first_d = e_cnt;
        last_d = e_cnt;
        n_done++;
      end
    end
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) begin
        if (n_done == 0) first_d = e_cnt;
        last_d = e_cnt;
        n_done++;
      end
    end
    chk("b2b_count", 32'(n_done), 32'd4);
    chk("b2b_span",  32'(last_d - first_d), 32'd18);

`ifdef SUBTRACT_EN
    start_op(16'h0005, 16'h0007, 1'b0, 1'b1);
    expect_result("s1", 16'hFFFE, 1'b0, 1'b0);
    start_op(16'h0007, 16'h0005, 1'b1, 1'b1);
    expect_result("s2", 16'h0002, 1'b1, 1'b0);
    set_sub(1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
